ixc_clock_phase_monitor: RTL and testbench



---
 rtl/ixc_clock_phase_monitor.sv | 162 ++++++++++++++++
 tb/tb_ixc_clock_phase_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ixc_clock_phase_monitor.sv
// Phase-length monitor for a generated clock sampled in the evaluation-clock domain.
// Measures every phase in emulation time units and reports lock, phase errors and stuck clocks.
module ixc_clock_phase_monitor #(
  parameter int EXPECTED_PHASE = 625,
  parameter int TOLERANCE      = 0,
  parameter int LOCK_COUNT     = 4,
  parameter int STUCK_LIMIT    = 2500,
  parameter int DELTA_W        = 11,
  parameter int ACC_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DELTA_W-1:0] delta,
  input  logic               phi_in,
  output logic               meas_valid,
  output logic [ACC_W-1:0]   meas_phase,
  output logic               meas_level,
  output logic               err_phase,
  output logic               err_stuck,
  output logic               locked,
  output logic [15:0]        edge_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [31:0] LO_LIM    = (EXPECTED_PHASE > TOLERANCE) ? 32'(EXPECTED_PHASE - TOLERANCE) : 32'd0;
  localparam logic [31:0] HI_LIM    = 32'(EXPECTED_PHASE + TOLERANCE);
  localparam logic [31:0] STUCK_LIM = 32'(STUCK_LIMIT);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_COUNT);

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic               phi_prev_q;
  logic [3:0]         good_cnt_q;
  logic               meas_valid_q;
  logic [ACC_W-1:0]   meas_phase_q;
  logic               meas_level_q;
  logic               err_phase_q;
  logic               err_stuck_q;
  logic               locked_q;
  logic [15:0]        edge_count_q;

  logic [ACC_W:0]     sum_wide_d;
  logic [ACC_W-1:0]   sum_d;
  logic               sat_d;
  logic               edge_d;
  logic               good_d;
  logic               stuck_d;

  // Saturating phase sum and per-cycle edge / tolerance / stuck decisions.
  always_comb begin
    sum_wide_d = {1'b0, acc_q} + {{(ACC_W + 1 - DELTA_W){1'b0}}, delta};
    sat_d      = sum_wide_d[ACC_W];
    sum_d      = sat_d ? {ACC_W{1'b1}} : sum_wide_d[ACC_W-1:0];
    edge_d     = (phi_in != phi_prev_q);
    // A saturated sum is never a trustworthy length, so it is always bad.
    good_d     = !sat_d && (32'(sum_d) >= LO_LIM) && (32'(sum_d) <= HI_LIM);
    stuck_d    = (32'(sum_d) > STUCK_LIM);
  end

  // Monitor FSM with registered measurement and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      phi_prev_q   <= 1'b0;
      good_cnt_q   <= 4'd0;
      meas_valid_q <= 1'b0;
      meas_phase_q <= '0;
      meas_level_q <= 1'b0;
      err_phase_q  <= 1'b0;
      err_stuck_q  <= 1'b0;
      locked_q     <= 1'b0;
      edge_count_q <= 16'd0;
    end else begin
      phi_prev_q   <= phi_in;
      meas_valid_q <= 1'b0;
      err_phase_q  <= 1'b0;
      if (!enable) begin
        state_q     <= IDLE;
        acc_q       <= '0;
        good_cnt_q  <= 4'd0;
        err_stuck_q <= 1'b0;
        locked_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= ACQUIRE;
            acc_q       <= '0;
            good_cnt_q  <= 4'd0;
            err_stuck_q <= 1'b0;
            locked_q    <= 1'b0;
          end
          ACQUIRE: begin
            if (edge_d) begin
              // Phase start unknown: the first measurement is thrown away.
              state_q      <= MEASURE;
              acc_q        <= '0;
              err_stuck_q  <= 1'b0;
              edge_count_q <= edge_count_q + 16'd1;
            end else if (stuck_d) begin
              acc_q       <= '0;
              err_stuck_q <= 1'b1;
            end else begin
              acc_q <= sum_d;
            end
          end
          MEASURE, LOCKED: begin
            if (edge_d) begin
              acc_q        <= '0;
              err_stuck_q  <= 1'b0;
              edge_count_q <= edge_count_q + 16'd1;
              meas_valid_q <= 1'b1;
              meas_phase_q <= sum_d;
              meas_level_q <= phi_prev_q;
              if (good_d) begin
                if (state_q == MEASURE) begin
                  if (good_cnt_q + 4'd1 >= LOCK_N) begin
                    state_q    <= LOCKED;
                    locked_q   <= 1'b1;
                    good_cnt_q <= LOCK_N;
                  end else begin
                    good_cnt_q <= good_cnt_q + 4'd1;
                  end
                end
              end else begin
                err_phase_q <= 1'b1;
                good_cnt_q  <= 4'd0;
                locked_q    <= 1'b0;
                state_q     <= MEASURE;
              end
            end else if (stuck_d) begin
              state_q     <= ACQUIRE;
              acc_q       <= '0;
              err_stuck_q <= 1'b1;
              locked_q    <= 1'b0;
              good_cnt_q  <= 4'd0;
            end else begin
              acc_q <= sum_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign meas_valid = meas_valid_q;
  assign meas_phase = meas_phase_q;
  assign meas_level = meas_level_q;
  assign err_phase  = err_phase_q;
  assign err_stuck  = err_stuck_q;
  assign locked     = locked_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_ixc_clock_phase_monitor.sv
// Directed bench for ixc_clock_phase_monitor: default instance plus a TOLERANCE=1
// instance and a 12-bit accumulator instance, all driven by the same stimulus.
module tb_ixc_clock_phase_monitor;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [10:0] delta;
  logic        phi_in;

  logic        a_mv, a_ml, a_ep, a_es, a_lk;
  logic [15:0] a_mp, a_ec;
  logic        b_mv, b_ml, b_ep, b_es, b_lk;
  logic [15:0] b_mp, b_ec;
  logic        c_mv, c_ml, c_ep, c_es, c_lk;
  logic [11:0] c_mp;
  logic [15:0] c_ec;

  int          n_vec;
  int          n_err;
  logic [15:0] exp_edges;
  logic        tb_idle;

  ixc_clock_phase_monitor u_a (
    .clk(clk), .rst(rst), .enable(enable), .delta(delta), .phi_in(phi_in),
    .meas_valid(a_mv), .meas_phase(a_mp), .meas_level(a_ml), .err_phase(a_ep),
    .err_stuck(a_es), .locked(a_lk), .edge_count(a_ec)
  );

  ixc_clock_phase_monitor #(.TOLERANCE(1)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .delta(delta), .phi_in(phi_in),
    .meas_valid(b_mv), .meas_phase(b_mp), .meas_level(b_ml), .err_phase(b_ep),
    .err_stuck(b_es), .locked(b_lk), .edge_count(b_ec)
  );

  ixc_clock_phase_monitor #(.ACC_W(12), .STUCK_LIMIT(4095)) u_c (
    .clk(clk), .rst(rst), .enable(enable), .delta(delta), .phi_in(phi_in),
    .meas_valid(c_mv), .meas_phase(c_mp), .meas_level(c_ml), .err_phase(c_ep),
    .err_stuck(c_es), .locked(c_lk), .edge_count(c_ec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] fa();
    return {a_mv, a_mp, a_ml, a_ep, a_es, a_lk};
  endfunction

  function automatic logic [20:0] fb();
    return {b_mv, b_mp, b_ml, b_ep, b_es, b_lk};
  endfunction

  function automatic logic [3:0] sa();
    return {a_mv, a_ep, a_es, a_lk};
  endfunction

  // One evaluation cycle; the edge model counts toggles seen outside IDLE while enabled.
  task automatic cyc(input logic [10:0] d, input logic p);
    if (enable && !tb_idle && (p != phi_in)) exp_edges = exp_edges + 16'd1;
    tb_idle = !enable;
    delta  = d;
    phi_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; delta = 11'd0; phi_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({fa(), a_ec} !== 37'd0) begin
      n_err++; $display("FAIL reset_state got %h exp %h", {fa(), a_ec}, 37'd0);
    end
    rst = 1'b0; tb_idle = 1'b1; exp_edges = 16'd0;
  endtask

  task automatic test_nominal();
    logic lvl;
    enable = 1'b1;
    cyc(11'd625, 1'b0);
    cyc(11'd625, 1'b1);
    n_vec++;
    if (sa() !== 4'b0000) begin
      n_err++; $display("FAIL nominal_first_edge got %b exp %b", sa(), 4'b0000);
    end
    for (int i = 1; i <= 4; i++) begin
      lvl = phi_in;
      cyc(11'd625, ~lvl);
      n_vec++;
      if (fa() !== {1'b1, 16'd625, lvl, 1'b0, 1'b0, (i == 4)}) begin
        n_err++; $display("FAIL nominal_meas%0d got %h exp %h", i, fa(), {1'b1, 16'd625, lvl, 1'b0, 1'b0, (i == 4)});
      end
    end
    n_vec++;
    if (a_ec !== 16'd5) begin
      n_err++; $display("FAIL nominal_edge_count got %0d exp %0d", a_ec, 5);
    end
  endtask

  task automatic test_mixed();
    logic p;
    p = phi_in;
    cyc(11'd200, p); cyc(11'd0, p); cyc(11'd300, p); cyc(11'd125, p);
    n_vec++;
    if (sa() !== 4'b0001) begin
      n_err++; $display("FAIL mixed_hold got %b exp %b", sa(), 4'b0001);
    end
    cyc(11'd0, ~p);
    n_vec++;
    if (fa() !== {1'b1, 16'd625, p, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL mixed_625 got %h exp %h", fa(), {1'b1, 16'd625, p, 1'b0, 1'b0, 1'b1});
    end
    p = phi_in;
    cyc(11'd200, p); cyc(11'd300, p); cyc(11'd125, p); cyc(11'd1, ~p);
    n_vec++;
    if (fa() !== {1'b1, 16'd626, p, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL mixed_626_tol0 got %h exp %h", fa(), {1'b1, 16'd626, p, 1'b1, 1'b0, 1'b0});
    end
    n_vec++;
    if (fb() !== {1'b1, 16'd626, p, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL mixed_626_tol1 got %h exp %h", fb(), {1'b1, 16'd626, p, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_loss_of_lock();
    logic p;
    for (int i = 1; i <= 4; i++) cyc(11'd625, ~phi_in);
    n_vec++;
    if (a_lk !== 1'b1) begin
      n_err++; $display("FAIL lol_relock got %b exp %b", a_lk, 1'b1);
    end
    p = phi_in;
    cyc(11'd625, p);
    cyc(11'd625, ~p);
    n_vec++;
    if (fa() !== {1'b1, 16'd1250, p, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL lol_long_phase got %h exp %h", fa(), {1'b1, 16'd1250, p, 1'b1, 1'b0, 1'b0});
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(11'd625, ~phi_in);
      n_vec++;
      if ({a_mv, a_ep, a_lk} !== {1'b1, 1'b0, (i == 4)}) begin
        n_err++; $display("FAIL lol_good%0d got %b exp %b", i, {a_mv, a_ep, a_lk}, {1'b1, 1'b0, (i == 4)});
      end
    end
  endtask

  task automatic test_stuck();
    logic p;
    p = phi_in;
    for (int i = 1; i <= 5; i++) begin
      cyc(11'd625, p);
      n_vec++;
      if (sa() !== ((i < 5) ? 4'b0001 : 4'b0010)) begin
        n_err++; $display("FAIL stuck_hold%0d got %b exp %b", i, sa(), ((i < 5) ? 4'b0001 : 4'b0010));
      end
    end
    cyc(11'd625, ~p);
    n_vec++;
    if (sa() !== 4'b0000) begin
      n_err++; $display("FAIL stuck_clear got %b exp %b", sa(), 4'b0000);
    end
    p = phi_in;
    cyc(11'd625, ~p);
    n_vec++;
    if (fa() !== {1'b1, 16'd625, p, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL stuck_resume got %h exp %h", fa(), {1'b1, 16'd625, p, 1'b0, 1'b0, 1'b0});
    end
    p = phi_in;
    repeat (4) cyc(11'd625, p);
    cyc(11'd625, ~p);
    n_vec++;
    if (fa() !== {1'b1, 16'd3125, p, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL stuck_edge_wins got %h exp %h", fa(), {1'b1, 16'd3125, p, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_enable_reset();
    logic p;
    for (int i = 1; i <= 4; i++) cyc(11'd625, ~phi_in);
    p = phi_in;
    cyc(11'd625, p);
    enable = 1'b0;
    cyc(11'd625, ~p);
    n_vec++;
    if ({sa(), a_ec} !== {4'b0000, exp_edges}) begin
      n_err++; $display("FAIL en_drop got %h exp %h", {sa(), a_ec}, {4'b0000, exp_edges});
    end
    cyc(11'd625, ~phi_in);
    n_vec++;
    if (a_ec !== exp_edges) begin
      n_err++; $display("FAIL en_idle_count got %0d exp %0d", a_ec, exp_edges);
    end
    enable = 1'b1;
    cyc(11'd625, phi_in);
    cyc(11'd625, ~phi_in);
    n_vec++;
    if (sa() !== 4'b0000) begin
      n_err++; $display("FAIL en_reacquire got %b exp %b", sa(), 4'b0000);
    end
    for (int i = 1; i <= 4; i++) cyc(11'd625, ~phi_in);
    n_vec++;
    if (a_lk !== 1'b1) begin
      n_err++; $display("FAIL en_relock got %b exp %b", a_lk, 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({fa(), a_ec} !== 37'd0) begin
      n_err++; $display("FAIL async_reset got %h exp %h", {fa(), a_ec}, 37'd0);
    end
    enable = 1'b0; phi_in = 1'b0;
    #1;
    rst = 1'b0; tb_idle = 1'b1; exp_edges = 16'd0;
    enable = 1'b1;
    cyc(11'd625, 1'b0);
    cyc(11'd625, 1'b1);
    n_vec++;
    if (sa() !== 4'b0000) begin
      n_err++; $display("FAIL rst_discard got %b exp %b", sa(), 4'b0000);
    end
    cyc(11'd625, 1'b0);
    n_vec++;
    if ({fa(), a_ec} !== {1'b1, 16'd625, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2}) begin
      n_err++; $display("FAIL rst_first_meas got %h exp %h", {fa(), a_ec}, {1'b1, 16'd625, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2});
    end
  endtask

  task automatic test_saturation();
    logic p;
    p = phi_in;
    cyc(11'd2047, p);
    cyc(11'd2047, p);
    cyc(11'd2047, ~p);
    n_vec++;
    if ({c_mv, c_mp, c_ml, c_ep, c_es} !== {1'b1, 12'hFFF, p, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sat_meas got %h exp %h", {c_mv, c_mp, c_ml, c_ep, c_es}, {1'b1, 12'hFFF, p, 1'b1, 1'b0});
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1; enable = 1'b0; phi_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; tb_idle = 1'b1; exp_edges = 16'd0;
    enable = 1'b1;
    cyc(11'd625, 1'b0);
    for (int i = 0; i < 65535; i++) cyc(11'd625, ~phi_in);
    n_vec++;
    if (a_ec !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_max got %0d exp %0d", a_ec, 16'hFFFF);
    end
    cyc(11'd625, ~phi_in);
    n_vec++;
    if ({a_ec, exp_edges} !== 32'd0) begin
      n_err++; $display("FAIL wrap_zero got %0d model %0d exp 0", a_ec, exp_edges);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_edges = 16'd0; tb_idle = 1'b1;
    rst = 1'b1; enable = 1'b0; delta = 11'd0; phi_in = 1'b0;
    test_reset();
    test_nominal();
    test_mixed();
    test_loss_of_lock();
    test_stuck();
    test_enable_reset();
    test_saturation();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
